// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and default widths for the Stage 1 compressor word
// FIFO and its consumer-side burst reader.
//   DEF_DATA_WIDTH : default FIFO word width
//   DEF_LEN_WIDTH  : default width of burst length / word counters
//   rd_state_t     : burst reader FSM states
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rd_out_stage.sv
// rd_out_stage: output holding register of the burst reader.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture d_in/last_in and mark the word valid
//   clear        : drop the held word (valid and last forced low)
//   ack          : downstream took the held word this cycle
//   d_in, last_in: next word and its end-of-burst marker
//   data, valid, last : registered stream outputs
// Priority is clear > load > ack, so a pop in the same cycle as the
// handshake replaces the word without a bubble.
module rd_out_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  last_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (clear) begin
      // data is left alone; only the qualifiers are dropped
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= d_in;
      valid <= 1'b1;
      last  <= last_in;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops exactly burst_len words from the compressor word
// FIFO on a start command and presents them as a valid/ready stream with a
// last marker on the final word.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start, burst_len   : begin a burst of burst_len words (sampled in IDLE)
//   abort              : synchronous cancel, wins over start and handshakes
//   fifo_empty, fifo_r_data, fifo_rd : FIFO read port (fifo_rd is the pop)
//   m_data, m_valid, m_last, m_ready : downstream stream
//   busy, done, words_sent           : status
//   dbg_state          : current FSM state (rd_state_t encoding)
//
// Stream handshake: a word transfers on every rising clk edge where
// m_valid & m_ready are both 1. Once m_valid is raised, m_data and m_last
// stay stable until that transfer (or an abort/reset). m_valid never
// depends on m_ready; fifo_rd does (combinationally), so m_ready must come
// from a register downstream.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_sent,
  output logic [1:0]            dbg_state
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  rd_state_t            state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 handshake;
  logic                 load;
  logic                 last_word;

  assign handshake = m_valid & m_ready;
  assign last_word = (remaining == ONE);

  // Pop when in RUN with words still owed, FIFO has data, and the output
  // register is free or being emptied this very cycle. Abort masks the pop
  // so a cancelled burst never consumes a FIFO word it will not deliver.
  assign load = (state == RUN) & ~fifo_empty & (remaining != '0) &
                (~m_valid | m_ready) & ~abort;

  assign fifo_rd   = load;
  assign dbg_state = state;

  rd_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .clear   (abort),
    .ack     (handshake),
    .d_in    (fifo_r_data),
    .last_in (last_word),
    .data    (m_data),
    .valid   (m_valid),
    .last    (m_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      len_q      <= '0;
      words_sent <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // words_sent deliberately keeps the partial count for diagnosis
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
      end else begin
        // Saturate at the latched length so a stray handshake cannot
        // overrun the count.
        if (handshake && (words_sent != len_q)) begin
          words_sent <= words_sent + ONE;
        end
        case (state)
          IDLE: begin
            if (start) begin
              len_q      <= burst_len;
              remaining  <= burst_len;
              words_sent <= '0;
              if (burst_len == '0) begin
                done <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (load) begin
              remaining <= remaining - ONE;
              if (last_word) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (handshake && m_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  burst_len = '0;
  logic        abort = 1'b0;
  logic        hold_empty = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_r_data;
  logic        fifo_rd;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  words_sent;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [31:0] exp_q[$];

  assign fifo_empty  = hold_empty | (wr_ptr == rd_ptr);
  assign fifo_r_data = mem[rd_ptr[7:0]];

  // The FIFO flushes whenever the reader is reset so both restart aligned.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_ptr <= wr_ptr;
    else if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  fifo_burst_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd    (fifo_rd),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent),
    .dbg_state  (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fifo_push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  // One burst: start in cycle 0, then drive m_ready / forced-empty either
  // from masks (bit k = cycle k) or randomly, checking every handshake
  // against the expected word queue.
  task automatic run_burst(input int len, input bit rand_mode, input int rdy_pct,
                           input int emp_pct, input logic [31:0] rdy_mask,
                           input logic [31:0] emp_mask, input int exp_done,
                           input int exp_first, input int gap_cyc);
    int hs = 0;
    int pops = 0;
    int done_cyc = -1;
    int first_cyc = -1;
    bit busy_seen = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] w;
    @(negedge clk);
    start = 1'b1; burst_len = len[7:0]; m_ready = 1'b1; hold_empty = 1'b0; abort = 1'b0;
    #1;
    check("idle_no_pop", fifo_rd, 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rand_mode) begin
        m_ready    = ($urandom_range(99) < rdy_pct);
        hold_empty = ($urandom_range(99) < emp_pct);
      end else begin
        m_ready    = (k < 32) ? rdy_mask[k] : 1'b1;
        hold_empty = (k < 32) ? emp_mask[k] : 1'b0;
      end
      #1;
      if (busy) busy_seen = 1;
      if (m_valid && first_cyc < 0) first_cyc = k;
      if (k == gap_cyc) check("underrun_valid_drop", m_valid, 0);
      if (prev_stall) begin
        check("stall_hold_data", m_data, prev_data);
        check("stall_hold_valid", m_valid, 1);
      end
      if (m_valid && !m_ready) check("stall_no_pop", fifo_rd, 0);
      if (hold_empty) check("empty_no_pop", fifo_rd, 0);
      if (fifo_rd) pops++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("stream_data", m_data, w);
        end
        check("stream_last", m_last, (hs + 1 == len));
        hs++;
      end
      if (done) begin
        done_cyc = k;
        check("done_busy_low", busy, 0);
        check("done_words_sent", words_sent, len);
        break;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    check("burst_done_seen", done_cyc >= 0, 1);
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    if (exp_first >= 0) check("first_valid_cycle", first_cyc, exp_first);
    check("handshake_count", hs, len);
    check("pop_count", pops, len);
    check("busy_seen", busy_seen, len != 0);
    m_ready = 1'b1;
    hold_empty = 1'b0;
  endtask

  typedef struct {
    int          len;
    logic [31:0] rdy_mask;
    logic [31:0] emp_mask;
    int          exp_done;
    int          exp_first;
    int          gap_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hs;
    int pops;
    logic [31:0] w;

    // plain burst, back-pressure stall, underrun, zero length, 1 and 7 words
    vecs[0] = '{4, 32'hFFFF_FFFF, 32'h0,  6,  2, -1};
    vecs[1] = '{3, ~32'h1C,       32'h0,  8,  2, -1};
    vecs[2] = '{5, 32'hFFFF_FFFF, 32'h78, 11, 2,  4};
    vecs[3] = '{0, 32'hFFFF_FFFF, 32'h0,  1, -1, -1};
    vecs[4] = '{1, 32'hFFFF_FFFF, 32'h0,  3,  2, -1};
    vecs[5] = '{7, 32'hFFFF_FFFF, 32'h0,  9,  2, -1};

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_sent", words_sent, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table-driven bursts ----------------
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].len; j++) begin
        if (i == 0) fifo_push(32'hA0 + j);
        else fifo_push($urandom);
      end
      run_burst(vecs[i].len, 1'b0, 0, 0, vecs[i].rdy_mask, vecs[i].emp_mask,
                vecs[i].exp_done, vecs[i].exp_first, vecs[i].gap_cyc);
    end

    // ---------------- new start in the done cycle ----------------
    fifo_push(32'h1111_0001);
    fifo_push(32'h1111_0002);
    @(negedge clk); start = 1'b1; burst_len = 8'd1; m_ready = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); #1;
    check("b2b_first_data", m_data, exp_q.pop_front());
    @(negedge clk); start = 1'b1; burst_len = 8'd1; #1;
    check("b2b_done", done, 1);
    @(negedge clk); start = 1'b0; #1;
    check("b2b_busy", busy, 1);
    check("b2b_pop", fifo_rd, 1);
    @(negedge clk); #1;
    check("b2b_valid", m_valid, 1);
    check("b2b_data", m_data, exp_q.pop_front());
    check("b2b_last", m_last, 1);
    @(negedge clk); #1;
    check("b2b_done2", done, 1);

    // ---------------- abort after 2 of 6 words ----------------
    for (int j = 0; j < 6; j++) fifo_push($urandom);
    hs = 0;
    pops = 0;
    @(negedge clk); start = 1'b1; burst_len = 8'd6; m_ready = 1'b1; #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 4);
      #1;
      if (k == 4) begin
        check("abort_valid_before", m_valid, 1);
        check("abort_no_pop", fifo_rd, 0);
      end
      if (fifo_rd) pops++;
      if (m_valid && m_ready && !abort) begin
        w = exp_q.pop_front();
        check("abort_stream_data", m_data, w);
        hs++;
      end
    end
    @(negedge clk); abort = 1'b0; #1;
    check("abort_valid", m_valid, 0);
    check("abort_last", m_last, 0);
    check("abort_state", dbg_state, 0);
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    check("abort_words_sent", words_sent, 2);
    // the popped-but-undelivered word is gone from the FIFO
    for (int j = hs; j < pops; j++) void'(exp_q.pop_front());
    run_burst(1, 1'b0, 0, 0, 32'hFFFF_FFFF, 32'h0, 3, 2, -1);

    // ---------------- asynchronous reset mid-burst ----------------
    for (int j = 0; j < 4; j++) fifo_push($urandom);
    @(negedge clk); start = 1'b1; burst_len = 8'd4; m_ready = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); #1;
    check("arst_valid_before", m_valid, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_last", m_last, 0);
    check("arst_busy", busy, 0);
    check("arst_words_sent", words_sent, 0);
    check("arst_pop", fifo_rd, 0);
    check("arst_state", dbg_state, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- randomized bursts ----------------
    for (int b = 0; b < 30; b++) begin
      int len;
      len = (b % 10 == 9) ? 0 : int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) fifo_push($urandom);
      run_burst(len, 1'b1, 70, 25, 32'h0, 32'h0, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
